// File: rtl/bus_mem_pkg.sv
// Shared types for the boot-loaded instruction memory that sits beside the PE.
package bus_mem_pkg;

  typedef enum logic [0:0] {
    BM_LOAD = 1'b0,
    BM_RUN  = 1'b1
  } bus_mem_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/bus_mem_ram.sv
// Word array with one synchronous write port and one registered read port.
// The array is deliberately left without reset so it maps onto block RAM.
module bus_mem_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_mem.sv
// Instruction memory target: filled from a byte stream while the PE is held
// in reset, then serves one-cycle-latency word fetches on the PE bus.
module bus_mem
  import bus_mem_pkg::*;
#(
  parameter int                AD_LEN      = 32,
  parameter int                BUS_WIDTH   = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [AD_LEN-1:0] BASE_AD     = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [AD_LEN-1:0]    bus_ad_i,
  output logic [BUS_WIDTH-1:0] bus_data_o,
  input  logic                 load_valid_i,
  input  logic [7:0]           load_data_i,
  input  logic                 load_last_i,
  output logic                 load_ready_o,
  output logic                 pe_reset_o,
  output logic                 fault_o
);

  localparam int LANES  = BUS_WIDTH / BYTE_W;
  localparam int SHIFT  = $clog2(LANES);
  localparam int LANE_W = (SHIFT > 0) ? SHIFT : 1;
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH_WORDS);
  localparam logic [AD_LEN-1:0] DEPTH_AD  = AD_LEN'(DEPTH_WORDS);

  bus_mem_state_t state, next_state;

  logic                 load_ready_q;
  logic [LANE_W-1:0]    lane;
  logic [BUS_WIDTH-1:0] asm_word;
  logic [BUS_WIDTH-1:0] word_next;
  logic [ADDR_W:0]      wptr;
  logic                 accept;
  logic                 word_done;
  logic                 mem_full;
  logic                 mem_we;
  logic [AD_LEN-1:0]    offset;
  logic [AD_LEN-1:0]    index;
  logic                 in_range;
  logic                 resp_ok_q;
  logic                 fault_q;
  logic [BUS_WIDTH-1:0] ram_rdata;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= BM_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // A last byte always closes the current word (unfilled lanes stay zero),
  // so the final image word is written even when it holds a single byte.
  always_comb begin
    next_state = state;
    accept     = load_valid_i && load_ready_q && (state == BM_LOAD);
    word_done  = accept && (load_last_i || (lane == LAST_LANE));
    mem_full   = (wptr == DEPTH_CNT);
    mem_we     = word_done && !mem_full && !reset_i;
    word_next  = asm_word;
    word_next[lane*BYTE_W +: BYTE_W] = load_data_i;
    if (accept && load_last_i) begin
      next_state = BM_RUN;
    end
  end

  always_comb begin
    offset   = bus_ad_i - BASE_AD;
    index    = offset >> SHIFT;
    in_range = (bus_ad_i >= BASE_AD) && (index < DEPTH_AD);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      load_ready_q <= 1'b0;
      lane         <= '0;
      asm_word     <= '0;
      wptr         <= '0;
      resp_ok_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      load_ready_q <= (next_state == BM_LOAD);
      if (accept) begin
        if (word_done) begin
          lane     <= '0;
          asm_word <= '0;
          if (!mem_full) begin
            wptr <= wptr + 1'b1;
          end
        end else begin
          lane     <= lane + 1'b1;
          asm_word <= word_next;
        end
      end
      resp_ok_q <= (state == BM_RUN) && in_range;
      fault_q   <= (state == BM_RUN) && !in_range;
    end
  end

  bus_mem_ram #(
    .WIDTH  (BUS_WIDTH),
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .we    (mem_we),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (word_next),
    .raddr (index[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign bus_data_o   = resp_ok_q ? ram_rdata : '0;
  assign fault_o      = fault_q;
  assign load_ready_o = load_ready_q;
  assign pe_reset_o   = (state == BM_LOAD);

endmodule

// File: tb/tb_bus_mem.sv
// Directed bench for bus_mem: three instances cover default geometry,
// a four-word memory and a non-zero base address.
module tb_bus_mem;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  lvalid;
  logic [2:0]  llast;
  logic [2:0]  lready;
  logic [2:0]  peres;
  logic [2:0]  fault;
  logic [7:0]  ldata [3];
  logic [31:0] bad   [3];
  logic [31:0] bdata [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_mem u_dut_def (
    .clk_i        (clk),
    .reset_i      (rst[0]),
    .bus_ad_i     (bad[0]),
    .bus_data_o   (bdata[0]),
    .load_valid_i (lvalid[0]),
    .load_data_i  (ldata[0]),
    .load_last_i  (llast[0]),
    .load_ready_o (lready[0]),
    .pe_reset_o   (peres[0]),
    .fault_o      (fault[0])
  );

  bus_mem #(.DEPTH_WORDS(4)) u_dut_small (
    .clk_i        (clk),
    .reset_i      (rst[1]),
    .bus_ad_i     (bad[1]),
    .bus_data_o   (bdata[1]),
    .load_valid_i (lvalid[1]),
    .load_data_i  (ldata[1]),
    .load_last_i  (llast[1]),
    .load_ready_o (lready[1]),
    .pe_reset_o   (peres[1]),
    .fault_o      (fault[1])
  );

  bus_mem #(.BASE_AD(32'h0000_1000)) u_dut_base (
    .clk_i        (clk),
    .reset_i      (rst[2]),
    .bus_ad_i     (bad[2]),
    .bus_data_o   (bdata[2]),
    .load_valid_i (lvalid[2]),
    .load_data_i  (ldata[2]),
    .load_last_i  (llast[2]),
    .load_ready_o (lready[2]),
    .pe_reset_o   (peres[2]),
    .fault_o      (fault[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut(input int d);
    rst[d]    = 1'b1;
    lvalid[d] = 1'b0;
    llast[d]  = 1'b0;
    ldata[d]  = 8'h00;
    bad[d]    = 32'h0;
    step();
    check_output("reset_pe_reset", 32'(peres[d]), 32'd1);
    check_output("reset_ready", 32'(lready[d]), 32'd0);
    check_output("reset_data", bdata[d], 32'h0);
    check_output("reset_fault", 32'(fault[d]), 32'd0);
    rst[d] = 1'b0;
    step();
    check_output("ready_after_reset", 32'(lready[d]), 32'd1);
  endtask

  task automatic apply_stimulus(input int d, input logic [7:0] b, input logic last);
    lvalid[d] = 1'b1;
    ldata[d]  = b;
    llast[d]  = last;
    step();
    lvalid[d] = 1'b0;
    llast[d]  = 1'b0;
  endtask

  task automatic read_word(input int d, input string tag, input logic [31:0] ad,
                           input logic [31:0] exp_data, input logic exp_fault);
    bad[d] = ad;
    step();
    check_output(tag, bdata[d], exp_data);
    check_output({tag, "_fault"}, 32'(fault[d]), 32'(exp_fault));
  endtask

  initial begin
    rst    = 3'b111;
    lvalid = 3'b000;
    llast  = 3'b000;
    for (int d = 0; d < 3; d++) begin
      ldata[d] = 8'h00;
      bad[d]   = 32'h0;
    end

    $display("[TB] eight-byte load, two full words");
    reset_dut(0);
    for (int i = 0; i < 7; i++) apply_stimulus(0, 8'(i), 1'b0);
    check_output("pe_reset_before_last", 32'(peres[0]), 32'd1);
    apply_stimulus(0, 8'h07, 1'b1);
    check_output("pe_reset_on_last", 32'(peres[0]), 32'd0);
    check_output("ready_on_last", 32'(lready[0]), 32'd0);
    read_word(0, "w0_full", 32'h0, 32'h0302_0100, 1'b0);
    read_word(0, "w1_full", 32'h4, 32'h0706_0504, 1'b0);

    $display("[TB] five-byte load, partial last word");
    reset_dut(0);
    apply_stimulus(0, 8'hAA, 1'b0);
    apply_stimulus(0, 8'hBB, 1'b0);
    apply_stimulus(0, 8'hCC, 1'b0);
    apply_stimulus(0, 8'hDD, 1'b0);
    apply_stimulus(0, 8'hEE, 1'b1);
    read_word(0, "partial_w1", 32'h4, 32'h0000_00EE, 1'b0);
    read_word(0, "partial_lowbits", 32'h6, 32'h0000_00EE, 1'b0);
    read_word(0, "partial_w0", 32'h0, 32'hDDCC_BBAA, 1'b0);

    $display("[TB] gapped load stream");
    reset_dut(0);
    for (int i = 0; i < 40; i++) begin
      lvalid[0] = (i % 3 == 0);
      ldata[0]  = 8'(8'h10 + i);
      llast[0]  = (i == 39);
      bad[0]    = 32'h0;
      step();
      if (i < 39) begin
        check_output("gap_ready", 32'(lready[0]), 32'd1);
        check_output("gap_load_data", bdata[0], 32'h0);
      end else begin
        check_output("gap_ready_after_last", 32'(lready[0]), 32'd0);
        check_output("gap_pe_reset_after_last", 32'(peres[0]), 32'd0);
      end
    end
    lvalid[0] = 1'b0;
    llast[0]  = 1'b0;
    read_word(0, "gap_w0", 32'h0, 32'h1916_1310, 1'b0);
    read_word(0, "gap_w2", 32'h8, 32'h312E_2B28, 1'b0);
    read_word(0, "gap_w3", 32'hC, 32'h0000_3734, 1'b0);

    $display("[TB] reset in the middle of a load");
    reset_dut(0);
    apply_stimulus(0, 8'h11, 1'b0);
    apply_stimulus(0, 8'h22, 1'b0);
    reset_dut(0);
    apply_stimulus(0, 8'h44, 1'b0);
    apply_stimulus(0, 8'h55, 1'b0);
    apply_stimulus(0, 8'h66, 1'b0);
    apply_stimulus(0, 8'h77, 1'b1);
    read_word(0, "restart_w0", 32'h0, 32'h7766_5544, 1'b0);
    read_word(0, "restart_w1_kept", 32'h4, 32'h2522_1F1C, 1'b0);

    $display("[TB] overflowing a four-word memory");
    reset_dut(1);
    for (int i = 0; i < 20; i++) apply_stimulus(1, 8'(i), (i == 19));
    check_output("small_pe_reset", 32'(peres[1]), 32'd0);
    read_word(1, "small_w3", 32'hC, 32'h0F0E_0D0C, 1'b0);
    read_word(1, "small_oob", 32'h10, 32'h0, 1'b1);
    read_word(1, "small_w0_after_fault", 32'h0, 32'h0302_0100, 1'b0);

    $display("[TB] non-zero base address");
    reset_dut(2);
    apply_stimulus(2, 8'hA1, 1'b0);
    apply_stimulus(2, 8'hB2, 1'b0);
    apply_stimulus(2, 8'hC3, 1'b0);
    apply_stimulus(2, 8'hD4, 1'b1);
    read_word(2, "base_below", 32'h0FFC, 32'h0, 1'b1);
    read_word(2, "base_w0", 32'h1000, 32'hD4C3_B2A1, 1'b0);
    read_word(2, "base_w0_lowbits", 32'h1003, 32'hD4C3_B2A1, 1'b0);
    read_word(2, "base_above", 32'h2000, 32'h0, 1'b1);
    bad[2] = 32'h1FFC;
    step();
    check_output("base_top_fault", 32'(fault[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
